// File: rtl/dualport_ram_pkg.sv
// Shared types and helpers for the dual-port RAM with clear engine.
// merge() works on a fixed maximum width; callers zero-extend and truncate.
package dualport_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int MAX_W     = 512;
  localparam int MAX_BYTES = MAX_W / 8;

  function automatic logic [MAX_W-1:0] merge(input logic [MAX_W-1:0]     old_w,
                                              input logic [MAX_W-1:0]     new_w,
                                              input logic [MAX_BYTES-1:0] be);
    logic [MAX_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_BYTES; i++)
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/dualport_ram_core.sv
// Storage array: byte-enable write port, registered read port that holds
// its last value between reads.
module dualport_ram_core
  import dualport_ram_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [WIDTH/8-1:0]   wbe,
  input  logic                 re,
  input  logic [ADDR_W-1:0]    raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk)
    if (we)
      mem[waddr] <= WIDTH'(merge(MAX_W'(mem[waddr]), MAX_W'(wdata), MAX_BYTES'(wbe)));

  // Read samples the pre-write contents on a same-address collision.
  always_comb rdata_d = re ? mem[raddr] : rdata_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;

  assign rdata = rdata_q;

endmodule

// File: rtl/dualport_ram_init.sv
// Dual-port RAM with byte enables, 1/2-cycle read latency, collision
// forwarding and a zero-fill engine that runs after reset or on clr.
module dualport_ram_init
  import dualport_ram_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 1,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [WIDTH/8-1:0]   byte_en,
  input  logic                 read,
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic                 clr,
  output logic [WIDTH-1:0]     data_out,
  output logic                 rd_valid,
  output logic                 collision,
  output logic                 init_busy
);

  localparam int              BYTES   = WIDTH / 8;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      ST_CLEAR:
        if (cnt_q == LAST) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      ST_READY:
        if (clr) begin
          state_d = ST_CLEAR;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end

  assign init_busy = busy_q;

  logic ready, wr_ok, rd_fire, rd_oor, hit;
  assign ready   = (state_q == ST_READY);
  assign wr_ok   = ready & write & ~clr & ({1'b0, wr_addr} < DEPTH_W);
  assign rd_fire = ready & read;
  assign rd_oor  = ({1'b0, rd_addr} >= DEPTH_W);
  assign hit     = wr_ok & (wr_addr == rd_addr);

  // Clear engine owns the write port for the whole fill.
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_waddr;
  logic [WIDTH-1:0]     mem_wdata, mem_rdata;
  logic [BYTES-1:0]     mem_be;
  assign mem_we    = ~ready | wr_ok;
  assign mem_waddr = ready ? wr_addr : cnt_q;
  assign mem_wdata = ready ? data_in : '0;
  assign mem_be    = ready ? byte_en : '1;

  dualport_ram_core #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_core (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .wbe   (mem_be),
    .re    (rd_fire & ~rd_oor),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  // Stage-1 side info travels with the read and holds until the next one.
  logic             vld1_q, vld1_d, oor1_q, oor1_d, hit1_q, hit1_d;
  logic [WIDTH-1:0] wd1_q, wd1_d;
  logic [BYTES-1:0] be1_q, be1_d;

  always_comb begin
    vld1_d = rd_fire;
    oor1_d = oor1_q;
    hit1_d = hit1_q;
    wd1_d  = wd1_q;
    be1_d  = be1_q;
    if (rd_fire) begin
      oor1_d = rd_oor;
      hit1_d = hit;
      wd1_d  = data_in;
      be1_d  = byte_en;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld1_q <= 1'b0;
      oor1_q <= 1'b0;
      hit1_q <= 1'b0;
      wd1_q  <= '0;
      be1_q  <= '0;
    end else begin
      vld1_q <= vld1_d;
      oor1_q <= oor1_d;
      hit1_q <= hit1_d;
      wd1_q  <= wd1_d;
      be1_q  <= be1_d;
    end

  logic [WIDTH-1:0] res1;
  logic             col1;
  always_comb begin
    res1 = mem_rdata;
    if (oor1_q)
      res1 = '0;
    else if ((BYPASS != 0) && hit1_q)
      res1 = WIDTH'(merge(MAX_W'(mem_rdata), MAX_W'(wd1_q), MAX_BYTES'(be1_q)));
  end
  assign col1 = vld1_q & hit1_q;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [WIDTH-1:0] dout2_q, dout2_d;
      logic             vld2_q, col2_q;

      always_comb dout2_d = vld1_q ? res1 : dout2_q;

      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          dout2_q <= '0;
          vld2_q  <= 1'b0;
          col2_q  <= 1'b0;
        end else begin
          dout2_q <= dout2_d;
          vld2_q  <= vld1_q;
          col2_q  <= col1;
        end

      assign data_out  = dout2_q;
      assign rd_valid  = vld2_q;
      assign collision = col2_q;
    end else begin : g_lat1
      assign data_out  = res1;
      assign rd_valid  = vld1_q;
      assign collision = col1;
    end
  endgenerate

endmodule

// File: tb/tb_dualport_ram_init.sv
// Bench: three configurations share one stimulus stream; each has its own
// expected-result queue checked whenever its rd_valid pulses.
module tb_dualport_ram_init;

  logic        clk = 1'b0;
  logic        rst;
  logic        write, read, clr;
  logic [3:0]  wr_addr, rd_addr;
  logic [15:0] data_in;
  logic [1:0]  byte_en;

  logic [7:0]  dout_a, dout_b;
  logic [15:0] dout_c;
  logic        vld_a, vld_b, vld_c, col_a, col_b, col_c, busy_a, busy_b, busy_c;

  always #5 clk = ~clk;

  // a: 8-bit, RD_LAT=1, write-first
  dualport_ram_init #(.WIDTH(8), .DEPTH(16), .RD_LAT(1), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .write(write), .wr_addr(wr_addr), .data_in(data_in[7:0]),
    .byte_en(byte_en[0:0]), .read(read), .rd_addr(rd_addr), .clr(clr),
    .data_out(dout_a), .rd_valid(vld_a), .collision(col_a), .init_busy(busy_a));

  // b: 8-bit, RD_LAT=2, read-old
  dualport_ram_init #(.WIDTH(8), .DEPTH(16), .RD_LAT(2), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .write(write), .wr_addr(wr_addr), .data_in(data_in[7:0]),
    .byte_en(byte_en[0:0]), .read(read), .rd_addr(rd_addr), .clr(clr),
    .data_out(dout_b), .rd_valid(vld_b), .collision(col_b), .init_busy(busy_b));

  // c: 16-bit, RD_LAT=1, write-first
  dualport_ram_init #(.WIDTH(16), .DEPTH(16), .RD_LAT(1), .BYPASS(1)) u_c (
    .clk(clk), .rst(rst), .write(write), .wr_addr(wr_addr), .data_in(data_in),
    .byte_en(byte_en), .read(read), .rd_addr(rd_addr), .clr(clr),
    .data_out(dout_c), .rd_valid(vld_c), .collision(col_c), .init_busy(busy_c));

  typedef struct {
    logic [15:0] d;
    logic        c;
    int          t;
  } exp_t;

  typedef struct {
    logic        w;
    logic [3:0]  wa;
    logic [15:0] d;
    logic [1:0]  be;
    logic        r;
    logic [3:0]  ra;
    logic [15:0] ea, eb, ec;
    logic        ecol;
  } vec_t;

  exp_t qa[$], qb[$], qc[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_out(input int k, input logic v, input logic c, input logic [15:0] d);
    exp_t e;
    int   lat;
    logic empty;
    lat   = (k == 1) ? 2 : 1;
    empty = 1'b0;
    if (c && !v) begin
      n_cmp++; n_bad++;
      $display("FAIL collision_without_valid inst=%0d got=1 want=0", k);
    end
    if (v) begin
      n_cmp++;
      if (k == 0) begin if (qa.size() == 0) empty = 1'b1; else e = qa.pop_front(); end
      else if (k == 1) begin if (qb.size() == 0) empty = 1'b1; else e = qb.pop_front(); end
      else begin if (qc.size() == 0) empty = 1'b1; else e = qc.pop_front(); end
      if (empty) begin
        n_bad++;
        $display("FAIL unexpected_rd_valid inst=%0d got=1 want=0 data=%h", k, d);
      end else if (d !== e.d || c !== e.c || (cyc - e.t) != lat) begin
        n_bad++;
        $display("FAIL read_result inst=%0d got data=%h col=%b lat=%0d want data=%h col=%b lat=%0d",
                 k, d, c, cyc - e.t, e.d, e.c, lat);
      end
    end
  endtask

  always @(negedge clk)
    if (!rst) begin
      chk_out(0, vld_a, col_a, {8'h00, dout_a});
      chk_out(1, vld_b, col_b, {8'h00, dout_b});
      chk_out(2, vld_c, col_c, dout_c);
    end

  task automatic drv(input logic w, input logic [3:0] wa, input logic [15:0] d,
                     input logic [1:0] be, input logic r, input logic [3:0] ra,
                     input logic c, input logic sb,
                     input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] ec,
                     input logic ecol);
    exp_t e;
    write = w; wr_addr = wa; data_in = d; byte_en = be;
    read = r; rd_addr = ra; clr = c;
    if (r && sb) begin
      e.c = ecol; e.t = cyc;
      e.d = ea; qa.push_back(e);
      e.d = eb; qb.push_back(e);
      e.d = ec; qc.push_back(e);
    end
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_busy(input logic exp, input string tag);
    n_cmp++;
    if (busy_a !== exp || busy_b !== exp || busy_c !== exp) begin
      n_bad++;
      $display("FAIL init_busy %s got=%b%b%b want=%b", tag, busy_a, busy_b, busy_c, exp);
    end
  endtask

  task automatic chk_rst_outs(input string tag);
    n_cmp++;
    if (dout_a !== 8'h0 || dout_b !== 8'h0 || dout_c !== 16'h0 || vld_a !== 1'b0 ||
        vld_b !== 1'b0 || vld_c !== 1'b0 || col_a !== 1'b0 || col_b !== 1'b0 ||
        col_c !== 1'b0) begin
      n_bad++;
      $display("FAIL %s got dout=%h/%h/%h vld=%b%b%b col=%b%b%b want all zero",
               tag, dout_a, dout_b, dout_c, vld_a, vld_b, vld_c, col_a, col_b, col_c);
    end
    chk_busy(1'b1, tag);
  endtask

  task automatic busy_window(input string tag);
    for (int i = 0; i < 16; i++) begin
      idle(1);
      chk_busy(i != 15, tag);
    end
  endtask

  task automatic read_all(input logic zero);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] z;
      z = zero ? 8'h00 : 8'(i);
      drv(0, 0, 0, 0, 1, 4'(i), 0, 1, {8'h00, z}, {8'h00, z}, {z, z}, 0);
    end
  endtask

  vec_t tbl[12];

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1, 3,  16'hAAAA, 2'b11, 0, 0,  16'h0,  16'h0,  16'h0,    0};
    tbl[1]  = '{1, 3,  16'h5555, 2'b01, 0, 0,  16'h0,  16'h0,  16'h0,    0};
    tbl[2]  = '{0, 0,  16'h0,    2'b00, 1, 3,  16'h55, 16'h55, 16'hAA55, 0};
    tbl[3]  = '{1, 5,  16'h1111, 2'b11, 0, 0,  16'h0,  16'h0,  16'h0,    0};
    tbl[4]  = '{1, 5,  16'h2222, 2'b11, 1, 5,  16'h22, 16'h11, 16'h2222, 1};
    tbl[5]  = '{0, 0,  16'h0,    2'b00, 1, 5,  16'h22, 16'h22, 16'h2222, 0};
    tbl[6]  = '{1, 6,  16'h9999, 2'b01, 1, 6,  16'h99, 16'h06, 16'h0699, 1};
    tbl[7]  = '{0, 0,  16'h0,    2'b00, 1, 6,  16'h99, 16'h99, 16'h0699, 0};
    tbl[8]  = '{1, 7,  16'hFFFF, 2'b00, 0, 0,  16'h0,  16'h0,  16'h0,    0};
    tbl[9]  = '{0, 0,  16'h0,    2'b00, 1, 7,  16'h07, 16'h07, 16'h0707, 0};
    tbl[10] = '{1, 10, 16'h3333, 2'b11, 1, 11, 16'h0B, 16'h0B, 16'h0B0B, 0};
    tbl[11] = '{0, 0,  16'h0,    2'b00, 1, 10, 16'h33, 16'h33, 16'h3333, 0};

    rst = 1'b1; write = 0; read = 0; clr = 0;
    wr_addr = 0; rd_addr = 0; data_in = 0; byte_en = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_rst_outs("reset_values");
    rst = 1'b0;

    // Initial clear; a write+read of address 2 mid-clear must be dropped.
    for (int i = 0; i < 16; i++) begin
      if (i == 3) drv(1, 2, 16'h7777, 2'b11, 1, 2, 0, 0, 0, 0, 0, 0);
      else        idle(1);
      chk_busy(i != 15, "init_clear");
    end
    read_all(1'b1);
    idle(3);

    for (int i = 0; i < 16; i++)
      drv(1, 4'(i), 16'(i * 257), 2'b11, 0, 0, 0, 0, 0, 0, 0, 0);
    read_all(1'b0);
    idle(3);

    for (int i = 0; i < 12; i++)
      drv(tbl[i].w, tbl[i].wa, tbl[i].d, tbl[i].be, tbl[i].r, tbl[i].ra, 0, 1,
          tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].ecol);
    idle(3);

    // clr with a same-cycle write (dropped) and read (serviced); one read in flight.
    drv(0, 0, 0, 0, 1, 8, 0, 1, 16'h08, 16'h08, 16'h0808, 0);
    drv(1, 9, 16'hEEEE, 2'b11, 1, 4, 1, 1, 16'h04, 16'h04, 16'h0404, 0);
    chk_busy(1'b1, "clr_rise");
    busy_window("clr_window");
    read_all(1'b1);
    idle(3);

    // Reset in the middle of a clr-started fill restarts the count.
    drv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk_busy(1'b1, "clr2_rise");
    idle(7);
    rst = 1'b1;
    qa.delete(); qb.delete(); qc.delete();
    #1;
    chk_rst_outs("async_reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    busy_window("restart_clear");
    drv(0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0, 0);
    idle(4);

    n_cmp++;
    if (qa.size() != 0 || qb.size() != 0 || qc.size() != 0) begin
      n_bad++;
      $display("FAIL drain got pending=%0d/%0d/%0d want=0/0/0", qa.size(), qb.size(), qc.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
